// File: rtl/req_arbiter.sv
// Request arbiter: fixed-priority or round-robin grant with a one-cycle dead slot between owners.
// Define REQ_ARBITER_TIMEOUT_EN to add the hold counter that force-releases a grant after HOLD_MAX cycles.
module req_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8,
    localparam int IW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id,
    output logic          timeout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          timeout_q, timeout_d;
    logic          win_found;
    logic [IW-1:0] win_id;
    logic [IW-1:0] idx;

`ifdef REQ_ARBITER_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX);
    logic [HW-1:0] hold_q, hold_d;
`endif

    // Winner search: upward from index 0 (fixed) or from rr_ptr with wrap (round-robin).
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = mode ? IW'((int'(rr_ptr_q) + i) % N) : IW'(i);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        rr_ptr_d  = rr_ptr_q;
        timeout_d = 1'b0;
`ifdef REQ_ARBITER_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            // RELEASE arbitrates like IDLE so a handover costs exactly one dead cycle.
            IDLE, RELEASE: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                if (win_found) begin
                    state_d        = GRANT;
                    gnt_d[win_id]  = 1'b1;
                    gnt_id_d       = win_id;
`ifdef REQ_ARBITER_TIMEOUT_EN
                    hold_d         = '0;
`endif
                end
            end
            GRANT: begin
                if (done[gnt_id_q]) begin
                    state_d  = RELEASE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    rr_ptr_d = (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + IW'(1);
                end
`ifdef REQ_ARBITER_TIMEOUT_EN
                else if (hold_q == HW'(HOLD_MAX - 1)) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    timeout_d = 1'b1;
                    rr_ptr_d  = (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + IW'(1);
                end else begin
                    hold_d = hold_q + HW'(1);
                end
`endif
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            rr_ptr_q  <= '0;
            timeout_q <= 1'b0;
`ifdef REQ_ARBITER_TIMEOUT_EN
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            rr_ptr_q  <= rr_ptr_d;
            timeout_q <= timeout_d;
`ifdef REQ_ARBITER_TIMEOUT_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench for req_arbiter (N=4, HOLD_MAX=8); expected outputs queued per step and checked after the edge.
module tb_req_arbiter;

    localparam int N        = 4;
    localparam int HOLD_MAX = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;

    typedef struct {
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
        logic       to;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    req_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++)
            if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
    task automatic step(input logic [3:0] r, input logic [3:0] d,
                        input logic [3:0] eg, input logic et, input string tag);
        exp_t e;
        req    = r;
        done   = d;
        e.g    = eg;
        e.v    = |eg;
        e.id   = idx_of(eg);
        e.to   = et;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert ({gnt, gnt_valid, gnt_id, timeout} === {e.g, e.v, e.id, e.to})
        else begin
            errors++;
            $error("FAIL %s: got gnt=%b v=%b id=%0d to=%b, expected gnt=%b v=%b id=%0d to=%b",
                   e.tag, gnt, gnt_valid, gnt_id, timeout, e.g, e.v, e.id, e.to);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;

        step(4'b1111, 4'b0000, 4'b0000, 1'b0, "reset_a");
        step(4'b1111, 4'b0000, 4'b0000, 1'b0, "reset_b");
        rst_n = 1'b1;
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, "idle_noreq");

        // Fixed priority handover 1 -> 3
        step(4'b1010, 4'b0000, 4'b0010, 1'b0, "fix_grant1");
        step(4'b1010, 4'b0000, 4'b0010, 1'b0, "fix_hold1");
        step(4'b1000, 4'b0010, 4'b0000, 1'b0, "fix_dead");
        step(4'b1000, 4'b0000, 4'b1000, 1'b0, "fix_grant3");
        step(4'b0000, 4'b1000, 4'b0000, 1'b0, "fix_rel3");
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, "fix_idle");

        // Round-robin rotation 0,1,2,3,0
        mode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] own;
            own = 4'b0001 << (k % 4);
            step(4'b1111, 4'b0000, own,     1'b0, $sformatf("rr_grant%0d", k));
            step(4'b1111, 4'b0000, own,     1'b0, $sformatf("rr_hold%0d", k));
            step(4'b1111, own,     4'b0000, 1'b0, $sformatf("rr_dead%0d", k));
        end
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, "rr_idle");

        // Reset mid-grant restores rr_ptr to 0 (rr_ptr is 1 here)
        step(4'b0001, 4'b0000, 4'b0001, 1'b0, "rst_grant0");
        rst_n = 1'b0;
        step(4'b0001, 4'b0000, 4'b0000, 1'b0, "rst_drop");
        rst_n = 1'b1;
        step(4'b0011, 4'b0000, 4'b0001, 1'b0, "rst_rrptr0");
        step(4'b0000, 4'b0001, 4'b0000, 1'b0, "rst_rel");
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, "rst_idle");

        // Non-owner done ignored; owner dropping req keeps grant
        mode = 1'b0;
        step(4'b0100, 4'b0000, 4'b0100, 1'b0, "own_grant2");
        step(4'b0100, 4'b1001, 4'b0100, 1'b0, "own_nonowner_done");
        step(4'b0000, 4'b0000, 4'b0100, 1'b0, "own_dropreq_a");
        step(4'b0000, 4'b0000, 4'b0100, 1'b0, "own_dropreq_b");
        step(4'b0000, 4'b0100, 4'b0000, 1'b0, "own_done");
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, "own_idle");

`ifdef REQ_ARBITER_TIMEOUT_EN
        // Forced release after HOLD_MAX grant cycles
        step(4'b0100, 4'b0000, 4'b0100, 1'b0, "to_grant");
        for (int k = 1; k < HOLD_MAX; k++)
            step(4'b0100, 4'b0000, 4'b0100, 1'b0, $sformatf("to_hold%0d", k));
        step(4'b0000, 4'b0000, 4'b0000, 1'b1, "to_pulse");
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, "to_after");

        // Done coinciding with the timeout point wins
        step(4'b0100, 4'b0000, 4'b0100, 1'b0, "tie_grant");
        for (int k = 1; k < HOLD_MAX; k++)
            step(4'b0100, 4'b0000, 4'b0100, 1'b0, $sformatf("tie_hold%0d", k));
        step(4'b0000, 4'b0100, 4'b0000, 1'b0, "tie_done");
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, "tie_idle");
`else
        // No forced release: grant held well past HOLD_MAX, timeout stays low
        step(4'b0100, 4'b0000, 4'b0100, 1'b0, "nto_grant");
        for (int k = 1; k < HOLD_MAX + 4; k++)
            step(4'b0100, 4'b0000, 4'b0100, 1'b0, $sformatf("nto_hold%0d", k));
        step(4'b0000, 4'b0100, 4'b0000, 1'b0, "nto_done");
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, "nto_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter: N, 4, number of requesters (2..8).
REQ-002 Parameter: HOLD_MAX, 8, maximum grant-hold cycles before forced release (2..255).
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: mode  input  1  arbitration policy: 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-006 Port: req  input  N  per-requester request level.
REQ-007 Port: done  input  N  per-requester release strobe; only the bit of the current owner is honoured.
REQ-008 Port: gnt  output  N  one-hot grant, registered.
REQ-009 Port: gnt_valid  output  1  high while any grant is held.
REQ-010 Port: gnt_id  output  $clog2(N)  index of current owner; 0 when gnt_valid low.
REQ-011 Port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-012 The FSM SHALL have three states: IDLE, GRANT, RELEASE.
REQ-013 In IDLE with req != 0, the FSM SHALL select a winner and enter GRANT; gnt/gnt_valid/gnt_id SHALL assert on the next edge (1-cycle request-to-grant latency).
REQ-014 In IDLE with req == 0, the FSM SHALL stay in IDLE; gnt SHALL stay 0.
REQ-015 Fixed priority: the winner SHALL be the lowest set index of req.
REQ-016 Round-robin: the winner SHALL be the first set bit of req searching upward from rr_ptr, wrapping N-1 -> 0.
REQ-017 rr_ptr SHALL update to (owner+1) mod N on entry to RELEASE in both modes; fixed mode ignores it.
REQ-018 mode SHALL be sampled only in IDLE; changes during GRANT/RELEASE SHALL take effect at the next arbitration.
REQ-019 In GRANT, the grant SHALL be held regardless of req changes, including owner dropping req.
REQ-020 In GRANT, done[gnt_id]=1 SHALL move the FSM to RELEASE; done bits of non-owners SHALL be ignored.
REQ-021 A hold counter SHALL clear on GRANT entry and increment each GRANT cycle; when it equals HOLD_MAX-1 without owner done, the FSM SHALL enter RELEASE and pulse timeout for exactly that transition cycle.
REQ-022 If owner done and the timeout condition coincide, done SHALL win: no timeout pulse.
REQ-023 In RELEASE, gnt, gnt_valid and gnt_id SHALL be 0 for exactly one cycle, then the FSM SHALL return to IDLE (dead cycle guarantees no back-to-back grant overlap).
REQ-024 gnt SHALL never have more than one bit set; gnt_valid SHALL equal |gnt.

Reset
REQ-025 On a rising edge with rst_n=0: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, hold counter=0, rr_ptr=0.
REQ-026 Reset asserted mid-GRANT SHALL drop the grant on that edge with no timeout pulse and no rr_ptr update.

Configuration
REQ-027 Macro REQ_ARBITER_TIMEOUT_EN: when defined, REQ-021/REQ-022 are implemented as specified.
REQ-028 Without REQ_ARBITER_TIMEOUT_EN, the hold counter SHALL be absent, grants SHALL be held until owner done, and timeout SHALL be tied to 0.

Verification
REQ-029 Fixed mode, req=4'b1010 in IDLE -> next cycle gnt=4'b0010, gnt_id=1; done=4'b0010 -> one zero cycle, then gnt=4'b1000.
REQ-030 Round-robin, req=4'b1111 held, owner pulses done after 2 cycles each -> grants 0,1,2,3,0 in order, each separated by one zero cycle.
REQ-031 Timeout enabled, HOLD_MAX=8, req=4'b0100, done never -> gnt=4'b0100 for 8 cycles, timeout high one cycle, gnt=0 next cycle.
REQ-032 Owner 2 granted, done=4'b1001 (non-owners) -> grant unchanged; owner drops req -> grant unchanged until done[2].
REQ-033 rst_n=0 while gnt=4'b0001 -> gnt=0, gnt_valid=0, timeout=0 on that edge; after release req=4'b0011 in round-robin mode -> grant index 0 (rr_ptr back to 0).
REQ-034 done[owner] on the same cycle hold counter reaches HOLD_MAX-1 -> RELEASE with timeout=0.
